// File: rtl/parking_sensor_conditioner.sv
// Input conditioning for the parking controller: synchronises and debounces the
// raw active-low entry/exit sensors and turns each car pass into one held request.
module parking_sensor_conditioner #(
   parameter int DEBOUNCE_CYCLES = 400000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       entry_sensor_n,
   input  logic       exit_sensor_n,
   input  logic [1:0] exit_slot_raw,
   input  logic       entry_ack,
   input  logic       exit_ack,
   output logic       entry_req_n,
   output logic       exit_req_n,
   output logic [1:0] exit_slot,
   output logic       entry_level_n,
   output logic       exit_level_n
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PENDING = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             entry_meta_q, entry_sync_q;
   logic             exit_meta_q, exit_sync_q;
   logic [1:0]       slot_meta_q, slot_sync_q;

   logic [CNT_W-1:0] entry_cnt_q, entry_cnt_d;
   logic             entry_level_q, entry_level_d;
   logic [CNT_W-1:0] exit_cnt_q, exit_cnt_d;
   logic             exit_level_q, exit_level_d;

   logic [1:0]       entry_state_q, entry_state_d;
   logic [1:0]       exit_state_q, exit_state_d;
   logic [1:0]       exit_slot_q, exit_slot_d;

   // Sensors idle high through the synchroniser so reset never fakes a car.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry_meta_q <= 1'b1;
         entry_sync_q <= 1'b1;
         exit_meta_q  <= 1'b1;
         exit_sync_q  <= 1'b1;
         slot_meta_q  <= 2'b00;
         slot_sync_q  <= 2'b00;
      end else begin
         entry_meta_q <= entry_sensor_n;
         entry_sync_q <= entry_meta_q;
         exit_meta_q  <= exit_sensor_n;
         exit_sync_q  <= exit_meta_q;
         slot_meta_q  <= exit_slot_raw;
         slot_sync_q  <= slot_meta_q;
      end
   end

   // Level only follows the synced input after DEBOUNCE_CYCLES stable cycles.
   always_comb begin
      entry_cnt_d   = entry_cnt_q;
      entry_level_d = entry_level_q;
      if (entry_sync_q == entry_level_q) begin
         entry_cnt_d = '0;
      end else if (entry_cnt_q == CNT_MAX) begin
         entry_level_d = entry_sync_q;
         entry_cnt_d   = '0;
      end else begin
         entry_cnt_d = entry_cnt_q + CNT_ONE;
      end
   end

   always_comb begin
      exit_cnt_d   = exit_cnt_q;
      exit_level_d = exit_level_q;
      if (exit_sync_q == exit_level_q) begin
         exit_cnt_d = '0;
      end else if (exit_cnt_q == CNT_MAX) begin
         exit_level_d = exit_sync_q;
         exit_cnt_d   = '0;
      end else begin
         exit_cnt_d = exit_cnt_q + CNT_ONE;
      end
   end

   // Requests rise with the level fall; an ack decides using the pre-edge level.
   always_comb begin
      entry_state_d = entry_state_q;
      case (entry_state_q)
         ST_IDLE: begin
            if (!entry_level_d) entry_state_d = ST_PENDING;
         end
         ST_PENDING: begin
            if (entry_ack) entry_state_d = entry_level_q ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (entry_level_d) entry_state_d = ST_IDLE;
         end
         default: entry_state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      exit_state_d = exit_state_q;
      exit_slot_d  = exit_slot_q;
      case (exit_state_q)
         ST_IDLE: begin
            if (!exit_level_d) begin
               exit_state_d = ST_PENDING;
               exit_slot_d  = slot_sync_q;
            end
         end
         ST_PENDING: begin
            if (exit_ack) exit_state_d = exit_level_q ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (exit_level_d) exit_state_d = ST_IDLE;
         end
         default: exit_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry_cnt_q   <= '0;
         entry_level_q <= 1'b1;
         exit_cnt_q    <= '0;
         exit_level_q  <= 1'b1;
         entry_state_q <= ST_IDLE;
         exit_state_q  <= ST_IDLE;
         exit_slot_q   <= 2'b00;
      end else begin
         entry_cnt_q   <= entry_cnt_d;
         entry_level_q <= entry_level_d;
         exit_cnt_q    <= exit_cnt_d;
         exit_level_q  <= exit_level_d;
         entry_state_q <= entry_state_d;
         exit_state_q  <= exit_state_d;
         exit_slot_q   <= exit_slot_d;
      end
   end

   assign entry_req_n   = (entry_state_q != ST_PENDING);
   assign exit_req_n    = (exit_state_q != ST_PENDING);
   assign exit_slot     = exit_slot_q;
   assign entry_level_n = entry_level_q;
   assign exit_level_n  = exit_level_q;

endmodule
